// File: rtl/note_pkg.sv
// Shared definitions for the note lane judge: judge codes, FSM encodings, lane width.
// Latency: none (constants and a pure function only).
// Backpressure: none.
package note_pkg;

    localparam int NOTE_LCD_COLS = 16;

    typedef logic [1:0] judge_t;

    localparam judge_t JUDGE_NONE    = 2'd0;
    localparam judge_t JUDGE_PERFECT = 2'd1;
    localparam judge_t JUDGE_GOOD    = 2'd2;
    localparam judge_t JUDGE_MISS    = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PLAY  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Hit and miss are mutually exclusive within a lane, so the order only documents intent.
    function automatic judge_t judge_code(input logic perfect, input logic good, input logic miss);
        judge_t j;
        j = JUDGE_NONE;
        if (perfect) begin
            j = JUDGE_PERFECT;
        end else if (good) begin
            j = JUDGE_GOOD;
        end else if (miss) begin
            j = JUDGE_MISS;
        end
        return j;
    endfunction

endpackage

// File: rtl/note_lane_judge_if.sv
// Bundle of game-side inputs and display-side outputs of the note lane judge.
// Latency: none (wiring only).
// Backpressure: none; every strobe is a single-cycle pulse with no ready.
interface note_lane_judge_if
    import note_pkg::*;
#(
    parameter int LCD_COLS = NOTE_LCD_COLS
) ();

    logic                i_tick_ms;
    logic                i_start;
    logic                i_note_t1;
    logic                i_note_t2;
    logic                i_btn_t1;
    logic                i_btn_t2;
    logic                i_game_end;
    logic [LCD_COLS-1:0] o_lane1;
    logic [LCD_COLS-1:0] o_lane2;
    judge_t              o_judge_t1;
    judge_t              o_judge_t2;
    logic                o_judge_vld;
    logic [15:0]         o_score;
    logic [7:0]          o_combo;
    logic [7:0]          o_max_combo;
    logic                o_done;

    modport master (
        output i_tick_ms, i_start, i_note_t1, i_note_t2, i_btn_t1, i_btn_t2, i_game_end,
        input  o_lane1, o_lane2, o_judge_t1, o_judge_t2, o_judge_vld,
        input  o_score, o_combo, o_max_combo, o_done
    );

    modport slave (
        input  i_tick_ms, i_start, i_note_t1, i_note_t2, i_btn_t1, i_btn_t2, i_game_end,
        output o_lane1, o_lane2, o_judge_t1, o_judge_t2, o_judge_vld,
        output o_score, o_combo, o_max_combo, o_done
    );

endinterface

// File: rtl/lane_shift_judge.sv
// One track's occupancy bitmap: judge a press, scroll toward column 0, then spawn at the top.
// Latency: bitmap updates one cycle after inputs; hit/miss strobes are combinational.
// Backpressure: none; spawn onto an occupied top column simply merges.
module lane_shift_judge
    import note_pkg::*;
#(
    parameter int LCD_COLS = NOTE_LCD_COLS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                btn,
    input  logic                shift,
    input  logic                spawn,
    output logic [LCD_COLS-1:0] lane,
    output logic                hit_perfect,
    output logic                hit_good,
    output logic                miss
);

    logic [LCD_COLS-1:0] lane_q;
    logic [LCD_COLS-1:0] judged;
    logic [LCD_COLS-1:0] shifted;
    logic [LCD_COLS-1:0] lane_nxt;

    // Judge on the registered bitmap, then shift what is left, then add the new note.
    always_comb begin
        hit_perfect = btn && lane_q[0];
        hit_good    = btn && !lane_q[0] && lane_q[1];
        judged      = lane_q;
        if (hit_perfect) begin
            judged[0] = 1'b0;
        end
        if (hit_good) begin
            judged[1] = 1'b0;
        end
        miss     = shift && judged[0];
        shifted  = shift ? (judged >> 1) : judged;
        lane_nxt = shifted;
        if (spawn) begin
            lane_nxt[LCD_COLS-1] = 1'b1;
        end
    end

    // Bitmap register; a new game empties it.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_nxt;
        end
    end

    assign lane = lane_q;

endmodule

// File: rtl/note_lane_judge.sv
// Rhythm-game judge: scrolls two note lanes, judges presses, keeps score and combo.
// Latency: all outputs registered, one cycle after the causing inputs.
// Backpressure: none; pulses arriving outside PLAY/DRAIN are dropped.
module note_lane_judge
    import note_pkg::*;
#(
    parameter int LCD_COLS    = NOTE_LCD_COLS,
    parameter int STEP_MS     = 120,
    parameter int PERFECT_PTS = 2,
    parameter int GOOD_PTS    = 1
) (
    input  logic             clk,
    input  logic             rst,
    note_lane_judge_if.slave bus
);

    localparam int              CNT_W    = (STEP_MS > 1) ? $clog2(STEP_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_MS - 1);

    logic [1:0]          state_q;
    logic [1:0]          state_nxt;
    logic [CNT_W-1:0]    step_cnt_q;
    logic                active;
    logic                start_play;
    logic                shift;
    logic                btn1;
    logic                btn2;
    logic                spawn1;
    logic                spawn2;
    logic [LCD_COLS-1:0] lane1;
    logic [LCD_COLS-1:0] lane2;
    logic                perfect1;
    logic                good1;
    logic                miss1;
    logic                perfect2;
    logic                good2;
    logic                miss2;
    judge_t              judge1_q;
    judge_t              judge2_q;
    logic                judge_vld_q;
    logic [15:0]         score_q;
    logic [7:0]          combo_q;
    logic [7:0]          max_combo_q;
    logic [16:0]         delta;
    logic [16:0]         score_sum;
    logic [15:0]         score_nxt;
    logic [1:0]          hits;
    logic [8:0]          combo_sum;
    logic [7:0]          combo_nxt;
    logic [7:0]          max_nxt;
    logic                any_miss;
    logic                any_event;

    // Notes only move and buttons only count while a game is running.
    assign active     = (state_q == ST_PLAY) || (state_q == ST_DRAIN);
    assign start_play = bus.i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign shift      = active && bus.i_tick_ms && (step_cnt_q == CNT_LAST);
    assign btn1       = active && bus.i_btn_t1;
    assign btn2       = active && bus.i_btn_t2;
    assign spawn1     = (state_q == ST_PLAY) && bus.i_note_t1;
    assign spawn2     = (state_q == ST_PLAY) && bus.i_note_t2;

    // Game phase sequencing; DRAIN waits for the last visible note to resolve.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (bus.i_start) state_nxt = ST_PLAY;
            ST_PLAY:  if (bus.i_game_end) state_nxt = ST_DRAIN;
            ST_DRAIN: if ((lane1 == '0) && (lane2 == '0)) state_nxt = ST_DONE;
            ST_DONE:  if (bus.i_start) state_nxt = ST_PLAY;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Millisecond accumulator that paces the scroll; wraps on the shift cycle.
    always_ff @(posedge clk) begin
        if (rst || start_play) begin
            step_cnt_q <= '0;
        end else if (active && bus.i_tick_ms) begin
            step_cnt_q <= shift ? '0 : step_cnt_q + CNT_W'(1);
        end
    end

    lane_shift_judge #(.LCD_COLS(LCD_COLS)) u_lane1 (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_play),
        .btn         (btn1),
        .shift       (shift),
        .spawn       (spawn1),
        .lane        (lane1),
        .hit_perfect (perfect1),
        .hit_good    (good1),
        .miss        (miss1)
    );

    lane_shift_judge #(.LCD_COLS(LCD_COLS)) u_lane2 (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_play),
        .btn         (btn2),
        .shift       (shift),
        .spawn       (spawn2),
        .lane        (lane2),
        .hit_perfect (perfect2),
        .hit_good    (good2),
        .miss        (miss2)
    );

    // Combine both lanes' strobes into saturating score, combo and best combo.
    always_comb begin
        delta = '0;
        if (perfect1) begin
            delta = 17'(PERFECT_PTS);
        end else if (good1) begin
            delta = 17'(GOOD_PTS);
        end
        if (perfect2) begin
            delta = delta + 17'(PERFECT_PTS);
        end else if (good2) begin
            delta = delta + 17'(GOOD_PTS);
        end
        score_sum = {1'b0, score_q} + delta;
        score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];

        hits      = {1'b0, perfect1 | good1} + {1'b0, perfect2 | good2};
        any_miss  = miss1 | miss2;
        any_event = perfect1 | good1 | miss1 | perfect2 | good2 | miss2;
        combo_sum = {1'b0, combo_q} + {7'b0, hits};
        if (any_miss) begin
            combo_nxt = {6'b0, hits};
        end else begin
            combo_nxt = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end
        max_nxt = (combo_nxt > max_combo_q) ? combo_nxt : max_combo_q;
    end

    // Score, combo and judge registers; a new game starts them from zero.
    always_ff @(posedge clk) begin
        if (rst || start_play) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            judge1_q    <= JUDGE_NONE;
            judge2_q    <= JUDGE_NONE;
            judge_vld_q <= 1'b0;
        end else begin
            score_q     <= score_nxt;
            combo_q     <= combo_nxt;
            max_combo_q <= max_nxt;
            judge_vld_q <= any_event;
            if (perfect1 || good1 || miss1) begin
                judge1_q <= judge_code(perfect1, good1, miss1);
            end
            if (perfect2 || good2 || miss2) begin
                judge2_q <= judge_code(perfect2, good2, miss2);
            end
        end
    end

    assign bus.o_lane1     = lane1;
    assign bus.o_lane2     = lane2;
    assign bus.o_judge_t1  = judge1_q;
    assign bus.o_judge_t2  = judge2_q;
    assign bus.o_judge_vld = judge_vld_q;
    assign bus.o_score     = score_q;
    assign bus.o_combo     = combo_q;
    assign bus.o_max_combo = max_combo_q;
    assign bus.o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_note_lane_judge.sv
// Bench for note_lane_judge: vector table, directed game sequences, random play vs a column model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_note_lane_judge;
    import note_pkg::*;

    localparam int STEP = 120;
    localparam int COLS = 16;

    localparam logic [7:0] K_RST   = 8'h80;
    localparam logic [7:0] K_START = 8'h40;
    localparam logic [7:0] K_N1    = 8'h20;
    localparam logic [7:0] K_N2    = 8'h10;
    localparam logic [7:0] K_B1    = 8'h08;
    localparam logic [7:0] K_B2    = 8'h04;
    localparam logic [7:0] K_GE    = 8'h02;
    localparam logic [7:0] K_TICK  = 8'h01;

    typedef struct packed {
        logic rst;
        logic start;
        logic n1;
        logic n2;
        logic b1;
        logic b2;
        logic ge;
        logic tick;
    } in_t;

    typedef struct packed {
        logic [7:0]  in;
        logic [15:0] l1;
        logic [15:0] l2;
        logic        done;
        logic        vld;
        logic [15:0] score;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    note_lane_judge_if bus ();

    note_lane_judge #(
        .LCD_COLS    (COLS),
        .STEP_MS     (STEP),
        .PERFECT_PTS (2),
        .GOOD_PTS    (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: phase 0 idle, 1 play, 2 drain, 3 done; notes as per-column flags.
    int m_st = 0;
    int m_cnt = 0;
    bit m_occ [2][COLS];
    int m_judge [2];
    bit m_vld = 0;
    int m_score = 0;
    int m_combo = 0;
    int m_max = 0;

    task automatic m_clear();
        for (int l = 0; l < 2; l++) begin
            for (int c = 0; c < COLS; c++) m_occ[l][c] = 0;
            m_judge[l] = 0;
        end
        m_cnt = 0;
        m_score = 0;
        m_combo = 0;
        m_max = 0;
    endtask

    task automatic model_step(input in_t v);
        bit active;
        bit shift;
        bit empty;
        bit anymiss;
        bit b;
        bit sp;
        int hits;
        int delta;
        int res;
        m_vld = 0;
        if (v.rst) begin
            m_clear();
            m_st = 0;
            return;
        end
        if ((m_st == 0 || m_st == 3) && v.start) begin
            m_clear();
            m_st = 1;
            return;
        end
        active = (m_st == 1 || m_st == 2);
        empty = 1;
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < COLS; c++)
                if (m_occ[l][c]) empty = 0;
        shift = 0;
        if (active && v.tick) begin
            if (m_cnt == STEP - 1) begin
                m_cnt = 0;
                shift = 1;
            end else begin
                m_cnt++;
            end
        end
        hits = 0;
        delta = 0;
        anymiss = 0;
        for (int l = 0; l < 2; l++) begin
            b = (l == 0) ? v.b1 : v.b2;
            sp = (l == 0) ? v.n1 : v.n2;
            res = -1;
            if (active && b) begin
                if (m_occ[l][0]) begin
                    m_occ[l][0] = 0; res = 1; hits++; delta += 2;
                end else if (m_occ[l][1]) begin
                    m_occ[l][1] = 0; res = 2; hits++; delta += 1;
                end
            end
            if (shift) begin
                if (m_occ[l][0]) begin
                    res = 3; anymiss = 1;
                end
                for (int c = 0; c < COLS - 1; c++) m_occ[l][c] = m_occ[l][c+1];
                m_occ[l][COLS-1] = 0;
            end
            if (m_st == 1 && sp) m_occ[l][COLS-1] = 1;
            if (res >= 0) begin
                m_judge[l] = res;
                m_vld = 1;
            end
        end
        m_score = (m_score + delta > 65535) ? 65535 : m_score + delta;
        if (anymiss) m_combo = hits;
        else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
        if (m_combo > m_max) m_max = m_combo;
        if (m_st == 1 && v.ge) m_st = 2;
        else if (m_st == 2 && empty) m_st = 3;
    endtask

    function automatic logic [15:0] m_lane(input int l);
        logic [15:0] r;
        r = '0;
        for (int c = 0; c < COLS; c++) r[c] = m_occ[l][c];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, sample after the edge.
    task automatic cycle(input logic [7:0] bits);
        in_t v;
        v = in_t'(bits);
        rst            = v.rst;
        bus.i_start    = v.start;
        bus.i_note_t1  = v.n1;
        bus.i_note_t2  = v.n2;
        bus.i_btn_t1   = v.b1;
        bus.i_btn_t2   = v.b2;
        bus.i_game_end = v.ge;
        bus.i_tick_ms  = v.tick;
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) cycle(K_TICK);
    endtask

    task automatic shifts(input int k);
        ticks(k * STEP);
    endtask

    task automatic expect_all(input string tag, input logic [15:0] l1, input logic [15:0] l2,
                              input judge_t j1, input judge_t j2, input int sc, input int cb,
                              input int mx, input logic dn);
        check({tag, ".lane1"}, bus.o_lane1, l1);
        check({tag, ".lane2"}, bus.o_lane2, l2);
        check({tag, ".judge1"}, bus.o_judge_t1, j1);
        check({tag, ".judge2"}, bus.o_judge_t2, j2);
        check({tag, ".score"}, bus.o_score, sc);
        check({tag, ".combo"}, bus.o_combo, cb);
        check({tag, ".max"}, bus.o_max_combo, mx);
        check({tag, ".done"}, bus.o_done, dn);
    endtask

    task automatic check_model();
        check("rnd.lane1", bus.o_lane1, m_lane(0));
        check("rnd.lane2", bus.o_lane2, m_lane(1));
        check("rnd.judge1", bus.o_judge_t1, m_judge[0]);
        check("rnd.judge2", bus.o_judge_t2, m_judge[1]);
        check("rnd.vld", bus.o_judge_vld, m_vld);
        check("rnd.score", bus.o_score, m_score);
        check("rnd.combo", bus.o_combo, m_combo);
        check("rnd.max", bus.o_max_combo, m_max);
        check("rnd.done", bus.o_done, m_st == 3);
    endtask

    function automatic vec_t mkv(input logic [7:0] i, input logic [15:0] l1, input logic [15:0] l2,
                                 input logic dn, input logic vld, input logic [15:0] sc);
        vec_t r;
        r.in = i; r.l1 = l1; r.l2 = l2; r.done = dn; r.vld = vld; r.score = sc;
        return r;
    endfunction

    vec_t tbl [10];
    logic ge_lvl;
    logic [7:0] rb;

    initial begin
        rst = 1'b0;
        bus.i_start = 0; bus.i_note_t1 = 0; bus.i_note_t2 = 0; bus.i_btn_t1 = 0;
        bus.i_btn_t2 = 0; bus.i_game_end = 0; bus.i_tick_ms = 0;

        tbl[0] = mkv(K_RST,               16'h0000, 16'h0000, 0, 0, 0);
        tbl[1] = mkv(K_START,             16'h0000, 16'h0000, 0, 0, 0);
        tbl[2] = mkv(K_N1,                16'h8000, 16'h0000, 0, 0, 0);
        tbl[3] = mkv(K_N2 | K_B1,         16'h8000, 16'h8000, 0, 0, 0);
        tbl[4] = mkv(K_N1,                16'h8000, 16'h8000, 0, 0, 0);
        tbl[5] = mkv(K_START,             16'h8000, 16'h8000, 0, 0, 0);
        tbl[6] = mkv(K_GE,                16'h8000, 16'h8000, 0, 0, 0);
        tbl[7] = mkv(K_GE | K_N1 | K_N2,  16'h8000, 16'h8000, 0, 0, 0);
        tbl[8] = mkv(K_RST,               16'h0000, 16'h0000, 0, 0, 0);
        tbl[9] = mkv(K_START,             16'h0000, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].in);
            check($sformatf("tbl%0d.lane1", i), bus.o_lane1, tbl[i].l1);
            check($sformatf("tbl%0d.lane2", i), bus.o_lane2, tbl[i].l2);
            check($sformatf("tbl%0d.done", i), bus.o_done, tbl[i].done);
            check($sformatf("tbl%0d.vld", i), bus.o_judge_vld, tbl[i].vld);
            check($sformatf("tbl%0d.score", i), bus.o_score, tbl[i].score);
        end

        // Walk one note from the top column to the hit column, then hit it.
        cycle(K_N1);
        check("walk0", bus.o_lane1, 16'h8000);
        for (int k = 1; k <= 15; k++) begin
            shifts(1);
            check($sformatf("walk%0d", k), bus.o_lane1, 16'h8000 >> k);
        end
        cycle(K_B1);
        expect_all("perfect", 16'h0000, 16'h0000, JUDGE_PERFECT, JUDGE_NONE, 2, 1, 1, 0);
        check("perfect.vld", bus.o_judge_vld, 1);
        cycle(8'h00);
        check("vld_pulse", bus.o_judge_vld, 0);

        // Spawn mid-step, then hit at column 1.
        ticks(50);
        cycle(K_N1 | K_TICK);
        ticks(69);
        check("mid_spawn", bus.o_lane1, 16'h4000);
        shifts(13);
        check("at_col1", bus.o_lane1, 16'h0002);
        cycle(K_B1);
        expect_all("good", 16'h0000, 16'h0000, JUDGE_GOOD, JUDGE_NONE, 3, 2, 2, 0);
        check("good.vld", bus.o_judge_vld, 1);

        // Unpressed note falls off column 0.
        cycle(K_N1);
        shifts(15);
        check("pre_miss", bus.o_lane1, 16'h0001);
        shifts(1);
        expect_all("miss", 16'h0000, 16'h0000, JUDGE_MISS, JUDGE_NONE, 3, 0, 2, 0);
        check("miss.vld", bus.o_judge_vld, 1);

        // Press lands on the same cycle as the shift.
        cycle(K_N2);
        shifts(15);
        check("pre_hitshift", bus.o_lane2, 16'h0001);
        ticks(STEP - 1);
        cycle(K_TICK | K_B2);
        expect_all("hitshift", 16'h0000, 16'h0000, JUDGE_MISS, JUDGE_PERFECT, 5, 1, 2, 0);

        // Build combo to 5, then one lane misses while the other hits.
        for (int r = 0; r < 2; r++) begin
            cycle(K_N1 | K_N2);
            shifts(15);
            cycle(K_B1 | K_B2);
            expect_all($sformatf("dual%0d", r), 16'h0000, 16'h0000, JUDGE_PERFECT, JUDGE_PERFECT,
                       9 + 4 * r, 3 + 2 * r, 3 + 2 * r, 0);
        end
        cycle(K_N1 | K_N2);
        shifts(15);
        check("pre_mixed1", bus.o_lane1, 16'h0001);
        check("pre_mixed2", bus.o_lane2, 16'h0001);
        ticks(STEP - 1);
        cycle(K_TICK | K_B2);
        expect_all("mixed", 16'h0000, 16'h0000, JUDGE_MISS, JUDGE_PERFECT, 15, 1, 5, 0);

        // End of song: drain the remaining note, spawns dropped, then restart.
        cycle(K_N1);
        shifts(7);
        check("pre_end", bus.o_lane1, 16'h0100);
        cycle(K_GE);
        check("drain.done", bus.o_done, 0);
        cycle(K_GE | K_N1);
        check("drain.drop", bus.o_lane1, 16'h0100);
        shifts(9);
        expect_all("drained", 16'h0000, 16'h0000, JUDGE_MISS, JUDGE_PERFECT, 15, 0, 5, 0);
        cycle(8'h00);
        check("done", bus.o_done, 1);
        cycle(K_B1 | K_TICK);
        check("done.btn_vld", bus.o_judge_vld, 0);
        check("done.hold", bus.o_done, 1);
        cycle(K_START);
        expect_all("restart", 16'h0000, 16'h0000, JUDGE_NONE, JUDGE_NONE, 0, 0, 0, 0);

        // Random play checked against the model every cycle.
        ge_lvl = 0;
        cycle(K_RST);
        cycle(K_START);
        for (int i = 0; i < 15000; i++) begin
            rb = '0;
            if ($urandom_range(0, 2999) == 0) ge_lvl = ~ge_lvl;
            if ($urandom_range(0, 3999) == 0) rb = rb | K_RST;
            if ($urandom_range(0, 399) == 0) rb = rb | K_START;
            if ($urandom_range(0, 29) == 0) rb = rb | K_N1;
            if ($urandom_range(0, 29) == 0) rb = rb | K_N2;
            if ($urandom_range(0, 5) == 0) rb = rb | K_B1;
            if ($urandom_range(0, 5) == 0) rb = rb | K_B2;
            if ($urandom_range(0, 7) != 0) rb = rb | K_TICK;
            if (ge_lvl) rb = rb | K_GE;
            cycle(rb);
            check_model();
        end

        // Reset in the middle of a game clears everything on the next cycle.
        cycle(K_RST);
        cycle(K_START);
        cycle(K_N1 | K_N2);
        ticks(2 * STEP);
        cycle(K_B1);
        check("pre_rst", bus.o_lane1, 16'h2000);
        cycle(K_RST | K_B2 | K_N1 | K_TICK);
        expect_all("rst_play", 16'h0000, 16'h0000, JUDGE_NONE, JUDGE_NONE, 0, 0, 0, 0);
        check("rst_play.vld", bus.o_judge_vld, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/note_lane_judge.md
Name: note_lane_judge

Overview:
- Consumes the per-track note spawn pulses from the note generator.
- Scrolls each note across a 16-column LCD lane toward the hit column (column 0).
- Judges player button presses against note positions, and keeps score and combo counts.
- Drives lane bitmaps to the LCD renderer and score and judge data to the display and FND logic.

Parameters:
- LCD_COLS, 16, columns per lane; notes spawn at column LCD_COLS-1.
- STEP_MS, 120, milliseconds between scroll steps.
- PERFECT_PTS, 2, score added for a column-0 hit.
- GOOD_PTS, 1, score added for a column-1 hit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_tick_ms  in  1  one-cycle strobe per elapsed millisecond, from the game timer
- i_start  in  1  one-cycle pulse; starts or restarts play
- i_note_t1  in  1  spawn pulse, track 1
- i_note_t2  in  1  spawn pulse, track 2
- i_btn_t1  in  1  debounced one-cycle press, track 1
- i_btn_t2  in  1  debounced one-cycle press, track 2
- i_game_end  in  1  level; song finished
- o_lane1  out  LCD_COLS  occupancy bitmap, track 1; bit 0 = hit column
- o_lane2  out  LCD_COLS  occupancy bitmap, track 2
- o_judge_t1  out  2  last judgement, track 1 (0 NONE, 1 PERFECT, 2 GOOD, 3 MISS)
- o_judge_t2  out  2  last judgement, track 2
- o_judge_vld  out  1  one-cycle pulse whenever either judge register is written
- o_score  out  16  accumulated score, saturating at 16'hFFFF
- o_combo  out  8  current combo, saturating at 255
- o_max_combo  out  8  best combo this game
- o_done  out  1  held high in DONE

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high. rst takes priority over every other input, including mid-game.
- Reset state: IDLE; all outputs 0; step counter 0.
- FSM states: IDLE, PLAY, DRAIN, DONE.
  - IDLE -> PLAY on i_start.
  - PLAY -> DRAIN when i_game_end=1.
  - DRAIN -> DONE when both lanes are 0.
  - DONE -> PLAY on i_start.
- Entering PLAY from IDLE or DONE:
  - Clears the lanes, score, combo, max_combo, judges and step counter.
  - The i_start cycle itself performs no spawn, shift or judge.
- i_start while in PLAY or DRAIN is ignored.
- Step counter:
  - Increments on each i_tick_ms in PLAY or DRAIN.
  - On reaching STEP_MS-1 with a tick, it wraps to 0 and asserts an internal shift for that cycle.
- Per-lane order within one cycle, evaluated on the registered (pre-update) bitmap:
  1. Judge. If the button is pressed:
     - bit0=1 -> PERFECT; clear bit0.
     - Otherwise bit1=1 -> GOOD; clear bit1.
     - Otherwise no effect: judge unchanged, no o_judge_vld.
  2. Shift. If shift is asserted, the lane shifts right by one. If bit0 is still set after judging, that note falls off and the lane records MISS.
  3. Spawn. In PLAY only, a spawn pulse sets bit LCD_COLS-1 after the shift. A spawn in DRAIN, IDLE or DONE is dropped.
- Spawn collision: a spawn on an already-set bit LCD_COLS-1 is absorbed (OR). There is no error.
- Registered outputs: o_lane1, o_lane2, judges and counters update one cycle after the causing inputs. o_judge_vld is asserted in that same cycle.
- Scoring, per cycle:
  - delta = sum of both lanes' hit points.
  - o_score <= min(score+delta, 16'hFFFF).
- Combo, per cycle:
  - If any lane records MISS: combo <= number of hits this cycle (0..2).
  - Otherwise: combo <= min(combo+hits, 255).
  - max_combo <= max(max_combo, new combo).
- A hit and a miss on different lanes in the same cycle are both judged.
- In DONE, buttons are ignored and o_lane1, o_lane2 are 0.

Decomposition:
- Shared package note_pkg:
  - Judge code constants JUDGE_NONE, JUDGE_PERFECT, JUDGE_GOOD, JUDGE_MISS.
  - FSM state encodings.
  - LCD_COLS default.
- One natural sub-module, lane_shift_judge, instantiated once per track. It holds the bitmap register and produces hit_perfect, hit_good and miss strobes.
- The parent holds the FSM, step counter, score, combo and max-combo logic.

Test Plan:
- Spawn reaches column 0: i_start; i_note_t1 in PLAY; 15 shifts (15×120 ticks) -> o_lane1 walks from 16'h8000 to 16'h0001.
- PERFECT and GOOD hits:
  - With the spawn at an arbitrary tick, press i_btn_t1 when o_lane1=16'h0001 -> o_judge_t1=1, o_score=2, o_combo=1, lane cleared.
  - Press at 16'h0002 -> o_judge_t1=2, score +1.
- Miss: no press; one more shift after 16'h0001 -> o_judge_t1=3, o_combo=0, o_score unchanged.
- Simultaneous hit and shift: press i_btn_t2 in the same cycle as the shift with o_lane2=16'h0001 -> PERFECT, no MISS, lane 16'h0000.
- Mixed cycle:
  - Starting state: combo=5, lane1=16'h0001, lane2=16'h0001.
  - Stimulus: shift with only i_btn_t2 pressed.
  - Response: t1 MISS, t2 PERFECT, combo=1, max_combo=5, score +2.
- End sequence:
  - i_game_end with one note at 16'h0100 -> DRAIN; a spawn during DRAIN is dropped.
  - After 9 shifts, o_done=1.
  - i_start then clears the score.
  - A separate run asserts rst mid-PLAY -> all outputs 0 on the next cycle.
